// File: rtl/sr_latch_pkg.sv
// Shared constants and elaboration helpers for the sr_latch_bank slice.
// Pure declarations: no latency, no flow control.
package sr_latch_pkg;

   localparam int CLR_FALL = 0;
   localparam int CLR_LOW  = 1;
   localparam int CLR_NONE = 2;

   function automatic bit cnt_w_valid(input int w);
      return (w >= 1) && (w <= 8);
   endfunction

   function automatic bit n_ch_valid(input int n);
      return (n >= 1) && (n <= 32);
   endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// Event/flag bus between event sources, the latch bank and the polling controller.
// Carries no state; the master drives en/set/clr and the slave returns registered flags and counts.
interface sr_latch_bank_if #(
   parameter int N_CH  = 8,
   parameter int CNT_W = 4
);
   logic                    en;
   logic [N_CH-1:0]         set;
   logic [N_CH-1:0]         clr;
   logic [N_CH-1:0]         q;
   logic                    any_q;
   logic                    en_fall;
   logic [N_CH*CNT_W-1:0]   cnt;
   logic [N_CH-1:0]         sat;

   modport master (
      output en, set, clr,
      input  q, any_q, en_fall, cnt, sat
   );

   modport slave (
      input  en, set, clr,
      output q, any_q, en_fall, cnt, sat
   );
endinterface

// File: rtl/sr_latch_ch.sv
// One latch channel: sticky flag with set-over-clear priority plus a saturating rising-edge counter.
// One-edge latency from sampled input to q/cnt/sat; no backpressure, every edge is evaluated.
module sr_latch_ch #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic             clear,
   input  logic             set_edge,
   output logic             q,
   output logic             q_nxt,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             set_d;
   logic             rise;
   logic             set_ev;
   logic [CNT_W-1:0] cnt_nxt;

   assign rise   = set & ~set_d;
   assign set_ev = set_edge ? rise : set;

   // Set wins over a coincident clear so an event arriving with an acknowledge is kept.
   always_comb begin
      q_nxt = q;
      if (set_ev)
         q_nxt = 1'b1;
      else if (clear)
         q_nxt = 1'b0;
   end

   always_comb begin
      cnt_nxt = cnt;
      if (clear)
         cnt_nxt = rise ? CNT_W'(1) : '0;
      else if (rise && (cnt != CNT_MAX))
         cnt_nxt = cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         set_d <= 1'b0;
         q     <= 1'b0;
         cnt   <= '0;
         sat   <= 1'b0;
      end else begin
         set_d <= set;
         q     <= q_nxt;
         cnt   <= cnt_nxt;
         sat   <= (cnt_nxt == CNT_MAX);
      end
   end
endmodule

// File: rtl/sr_latch_bank.sv
// Multi-channel sticky set/reset latch bank with shared enable-driven clearing and event counters.
// All outputs registered, one-edge latency; no backpressure, events are never stalled.
module sr_latch_bank
   import sr_latch_pkg::*;
#(
   parameter int N_CH     = 8,
   parameter int CNT_W    = 4,
   parameter int CLR_MODE = 0,
   parameter int SET_EDGE = 1
) (
   input  logic             clk,
   input  logic             rst,
   sr_latch_bank_if.slave   bus
);
   if (!cnt_w_valid(CNT_W)) begin : g_bad_cnt_w
      $error("sr_latch_bank: CNT_W out of range 1..8");
   end
   if (!n_ch_valid(N_CH)) begin : g_bad_n_ch
      $error("sr_latch_bank: N_CH out of range 1..32");
   end

   logic                  en_d;
   logic                  en_fall_cmb;
   logic                  ec;
   logic [N_CH-1:0]       ch_clear;
   logic [N_CH-1:0]       q_w;
   logic [N_CH-1:0]       q_nxt;
   logic [N_CH-1:0]       sat_w;
   logic [N_CH*CNT_W-1:0] cnt_w;

   // en_d resets low so an enable held across reset never looks like a falling edge.
   assign en_fall_cmb = en_d & ~bus.en;

   always_comb begin
      ec = 1'b0;
      case (CLR_MODE)
         CLR_FALL: ec = en_fall_cmb;
         CLR_LOW:  ec = ~bus.en;
         default:  ec = 1'b0;
      endcase
   end

   assign ch_clear = bus.clr | {N_CH{ec}};

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      sr_latch_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .set      (bus.set[i]),
         .clear    (ch_clear[i]),
         .set_edge (SET_EDGE != 0),
         .q        (q_w[i]),
         .q_nxt    (q_nxt[i]),
         .cnt      (cnt_w[i*CNT_W +: CNT_W]),
         .sat      (sat_w[i])
      );
   end

   // any_q comes from next-state q so it lines up with q on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_d        <= 1'b0;
         bus.en_fall <= 1'b0;
         bus.any_q   <= 1'b0;
      end else begin
         en_d        <= bus.en;
         bus.en_fall <= en_fall_cmb;
         bus.any_q   <= |q_nxt;
      end
   end

   assign bus.q   = q_w;
   assign bus.cnt = cnt_w;
   assign bus.sat = sat_w;
endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench: mode-0 edge-set bank driven from a vector table, mode-1 level-set bank by hand.
module tb_sr_latch_bank;
   logic clk;
   logic rst_a;
   logic rst_b;
   int   checks;
   int   failures;

   sr_latch_bank_if #(.N_CH(4), .CNT_W(3)) bus_a ();
   sr_latch_bank_if #(.N_CH(4), .CNT_W(3)) bus_b ();

   sr_latch_bank #(.N_CH(4), .CNT_W(3), .CLR_MODE(0), .SET_EDGE(1)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   sr_latch_bank #(.N_CH(4), .CNT_W(3), .CLR_MODE(1), .SET_EDGE(0)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        rst;
      logic        en;
      logic [3:0]  set;
      logic [3:0]  clr;
      logic [3:0]  q;
      logic        any;
      logic        fall;
      logic [11:0] cnt;
      logic [3:0]  sat;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string tag, input logic r, input logic e, input logic [3:0] s,
                      input logic [3:0] c, input logic [3:0] q, input logic any,
                      input logic fall, input logic [11:0] cnt, input logic [3:0] sat);
      vec_t v;
      v.tag = tag; v.rst = r; v.en = e; v.set = s; v.clr = c;
      v.q = q; v.any = any; v.fall = fall; v.cnt = cnt; v.sat = sat;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic check_a(input string tag, input logic [3:0] q, input logic any,
                          input logic fall, input logic [11:0] cnt, input logic [3:0] sat);
      chk({tag, ".q"},       32'(bus_a.q),       32'(q));
      chk({tag, ".any_q"},   32'(bus_a.any_q),   32'(any));
      chk({tag, ".en_fall"}, 32'(bus_a.en_fall), 32'(fall));
      chk({tag, ".cnt"},     32'(bus_a.cnt),     32'(cnt));
      chk({tag, ".sat"},     32'(bus_a.sat),     32'(sat));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic r, input logic e, input logic [3:0] s, input logic [3:0] c);
      rst_a = r; bus_a.en = e; bus_a.set = s; bus_a.clr = c;
   endtask

   initial begin
      logic [2:0] c3;
      checks   = 0;
      failures = 0;
      drive_a(1'b1, 1'b1, 4'hF, 4'h0);
      rst_b = 1'b1; bus_b.en = 1'b0; bus_b.set = 4'h0; bus_b.clr = 4'h0;

      //   tag         rst en  set      clr      q        any fall cnt      sat
      add("rst0",      1, 1, 4'hF,    4'h0,    4'h0,    0, 0, 12'h000, 4'h0);
      add("rst1",      1, 1, 4'hF,    4'h0,    4'h0,    0, 0, 12'h000, 4'h0);
      add("release",   0, 1, 4'h0,    4'h0,    4'h0,    0, 0, 12'h000, 4'h0);
      add("set0101",   0, 1, 4'b0101, 4'h0,    4'b0101, 1, 0, 12'h041, 4'h0);
      add("hold",      0, 1, 4'h0,    4'h0,    4'b0101, 1, 0, 12'h041, 4'h0);
      add("en_fall",   0, 0, 4'h0,    4'h0,    4'h0,    0, 1, 12'h000, 4'h0);
      add("en_low",    0, 0, 4'h0,    4'h0,    4'h0,    0, 0, 12'h000, 4'h0);
      add("en_rise",   0, 1, 4'h0,    4'h0,    4'h0,    0, 0, 12'h000, 4'h0);
      add("set_ch0",   0, 1, 4'b0001, 4'h0,    4'b0001, 1, 0, 12'h001, 4'h0);
      add("set_clr1",  0, 1, 4'b0010, 4'b0010, 4'b0011, 1, 0, 12'h009, 4'h0);
      add("clr1",      0, 1, 4'h0,    4'b0010, 4'b0001, 1, 0, 12'h001, 4'h0);

      foreach (vecs[i]) begin
         drive_a(vecs[i].rst, vecs[i].en, vecs[i].set, vecs[i].clr);
         step();
         check_a(vecs[i].tag, vecs[i].q, vecs[i].any, vecs[i].fall, vecs[i].cnt, vecs[i].sat);
      end

      // Saturation on ch3: 9 pulses, counter pins at 7.
      for (int k = 1; k <= 9; k++) begin
         drive_a(1'b0, 1'b1, 4'b1000, 4'h0);
         step();
         c3 = (k >= 7) ? 3'd7 : 3'(k);
         check_a($sformatf("sat_k%0d", k), 4'b1001, 1'b1, 1'b0, {c3, 9'b000_000_001},
                 (k >= 7) ? 4'b1000 : 4'b0000);
         drive_a(1'b0, 1'b1, 4'h0, 4'h0);
         step();
      end
      drive_a(1'b0, 1'b1, 4'h0, 4'b1000);
      step();
      check_a("clr3", 4'b0001, 1'b1, 1'b0, 12'h001, 4'h0);

      // Reset mid-operation with all channels at count 3.
      drive_a(1'b0, 1'b1, 4'h0, 4'hF);
      step();
      check_a("clr_all", 4'h0, 1'b0, 1'b0, 12'h000, 4'h0);
      for (int k = 0; k < 3; k++) begin
         drive_a(1'b0, 1'b1, 4'hF, 4'h0);
         step();
         drive_a(1'b0, 1'b1, 4'h0, 4'h0);
         step();
      end
      check_a("pre_rst", 4'hF, 1'b1, 1'b0, 12'h6DB, 4'h0);
      drive_a(1'b1, 1'b1, 4'hF, 4'h0);
      step();
      check_a("mid_rst", 4'h0, 1'b0, 1'b0, 12'h000, 4'h0);
      drive_a(1'b0, 1'b1, 4'hF, 4'h0);
      step();
      check_a("post_rst1", 4'hF, 1'b1, 1'b0, 12'h249, 4'h0);
      drive_a(1'b0, 1'b1, 4'h0, 4'h0);
      step();
      check_a("post_rst_hold", 4'hF, 1'b1, 1'b0, 12'h249, 4'h0);
      drive_a(1'b0, 1'b1, 4'hF, 4'h0);
      step();
      check_a("post_rst2", 4'hF, 1'b1, 1'b0, 12'h492, 4'h0);

      // Mode 1, level set: en low clears every edge unless set is still asserted.
      rst_b = 1'b0; bus_b.en = 1'b0; bus_b.set = 4'b0100;
      step();
      chk("m1_set.q",   32'(bus_b.q),   32'h4);
      chk("m1_set.cnt", 32'(bus_b.cnt), 32'h040);
      chk("m1_set.any", 32'(bus_b.any_q), 32'h1);
      step();
      chk("m1_held.q",   32'(bus_b.q),   32'h4);
      chk("m1_held.cnt", 32'(bus_b.cnt), 32'h000);
      bus_b.set = 4'h0;
      step();
      chk("m1_rel.q",   32'(bus_b.q),     32'h0);
      chk("m1_rel.any", 32'(bus_b.any_q), 32'h0);
      bus_b.en = 1'b1; bus_b.set = 4'b0100;
      step();
      chk("m1_en.q",   32'(bus_b.q),   32'h4);
      chk("m1_en.cnt", 32'(bus_b.cnt), 32'h040);
      bus_b.set = 4'h0;
      step();
      chk("m1_en_hold.q",    32'(bus_b.q),       32'h4);
      chk("m1_en_hold.fall", 32'(bus_b.en_fall), 32'h0);
      bus_b.en = 1'b0;
      step();
      chk("m1_drop.q",    32'(bus_b.q),       32'h0);
      chk("m1_drop.fall", 32'(bus_b.en_fall), 32'h1);
      step();
      chk("m1_drop2.fall", 32'(bus_b.en_fall), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sr_latch_bank.md
Name: sr_latch_bank

Overview:
Parametrised multi-channel set/reset latch bank, the successor to the single-channel enable-cleared latch. Each channel captures set events into a sticky flag and counts them in a saturating counter. Flags are cleared by a falling edge of the shared enable, by a level-low enable, or by a per-channel clear, depending on mode. The block sits between event sources (comparators, fault detectors) and the digital control logic that polls and acknowledges flags.

Parameters:
N_CH, 8, number of independent latch channels (1..32)
CNT_W, 4, width of the per-channel saturating event counter (1..8)
CLR_MODE, 0, enable-clear mode: 0 = clear on en falling edge; 1 = clear while en low; 2 = en ignored (per-channel clr only)
SET_EDGE, 1, 1 = latch on rising edge of set[i]; 0 = latch on set[i] level high

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous active-high reset
en  in  1  shared enable; its falling edge or low level clears flags per CLR_MODE
set  in  N_CH  per-channel set request
clr  in  N_CH  per-channel explicit clear (acknowledge), level-sensitive
q  out  N_CH  registered sticky flag per channel
any_q  out  1  registered OR of all q bits
en_fall  out  1  one-cycle pulse, registered, marks a detected en falling edge
cnt  out  N_CH*CNT_W  per-channel saturating set-event counts, channel i at [i*CNT_W +: CNT_W]
sat  out  N_CH  per-channel flag: counter at max (2^CNT_W-1)

Behaviour:
- Reset (rst=1 at posedge): q=0, any_q=0, en_fall=0, cnt=0, sat=0, internal en_d=0, set_d=0. Reset overrides everything. Reset mid-operation discards all pending state in the same cycle.
- en_d and set_d are registered copies of en and set. Because en_d=0 after reset, en held high or low across reset never produces a false falling edge.
- Set event, ch i: SET_EDGE=1 -> set[i] & ~set_d[i]; SET_EDGE=0 -> set[i].
- Enable clear (ec): mode 0 -> en_d & ~en; mode 1 -> ~en; mode 2 -> 0.
- Channel clear: clr[i] | ec.
- Next state q[i]:
  - set event -> 1.
  - else channel clear -> 0.
  - else hold.
  - Set wins over any simultaneous clear, so no event is lost.
- Latency: q rises at the first posedge where the set event is sampled. q is visible one cycle after the input change settles before the edge. Clear has the same one-edge latency.
- Counter, ch i:
  - Increments on each rising edge of set[i] (independent of SET_EDGE), saturating at 2^CNT_W-1.
  - Reset to 0 by channel clear unless a rising edge occurs in the same cycle; then it loads 1.
  - sat[i] = (cnt_i == max), registered with cnt.
- any_q is registered alongside q from next-state q, so it tracks q with no extra cycle.
- en_fall is registered (en_d & ~en) in all modes, including mode 2, for software observation.
- Mode 1: flags can be set while en low but clear on the next edge unless set persists. With SET_EDGE=0 and set held, q remains 1.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package sr_latch_pkg:
  - CLR_MODE constants CLR_FALL=0, CLR_LOW=1, CLR_NONE=2.
  - Width-check function for CNT_W.
- Sub-module sr_latch_ch:
  - One channel: set edge detect, q register, saturating counter, sat.
  - Inputs: clk, rst, set, clear, set-edge select.
  - Generated N_CH times.
  - Top owns en edge detection, ec generation, any_q and output packing.

Test Plan:
- Reset: N_CH=4, CNT_W=3, mode 0. Hold rst=1 with set=4'hF, en=1 -> q=0, cnt=0, any_q=0. Release with en=1 -> no en_fall pulse.
- Set then enable-fall clear: pulse set=4'b0101 for one cycle -> next cycle q=4'b0101, any_q=1, cnt0=cnt2=1. Drop en 1->0 -> en_fall=1 for exactly one cycle, q=0, cnt=0 on that edge.
- Simultaneous set and clear: assert set[1] rising and clr[1]=1 on the same edge -> q[1]=1, cnt1=1. Then clr[1] alone -> q[1]=0, cnt1=0. Channels 0, 2, 3 unaffected.
- Saturation: 9 rising edges on set[3] with CNT_W=3 -> cnt3 stops at 7, sat[3]=1. clr[3] -> cnt3=0, sat[3]=0.
- Mode 1, SET_EDGE=0: en=0, hold set[2]=1 -> q[2] stays 1. Release set[2] -> q[2]=0 on the next edge. en=1 -> flags hold after subsequent set pulses.
- Reset mid-operation: q=4'b1111, cnt=3 each, assert rst for one cycle while set toggles -> all outputs 0. The following cycle counts only new rising edges.
